hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 135 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline with a multi-cycle mul/div unit.
// Tracks destination URAs in E/M/W and, for the D-stage sources, produces
// a stall request and forwarding selects. A down-counter models mul/div
// occupancy; it keeps running through a flush so an issued operation finishes.
module hazard_scoreboard (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] d_rs_ura,
   input  logic [6:0] d_rt_ura,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [6:0] d_dst_ura,
   input  logic [1:0] d_tnew,
   input  logic       d_valid,
   input  logic       d_md_start,
   input  logic       d_md_div,
   input  logic       flush,
   output logic       stall,
   output logic [1:0] fwd_rs_sel,
   output logic [1:0] fwd_rt_sel,
   output logic       md_busy
);

   localparam logic [3:0] MUL_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES = 4'd10;

   logic [6:0] e_dst_q, m_dst_q, w_dst_q;
   logic [1:0] e_tnew_q, m_tnew_q, w_tnew_q;
   logic [6:0] e_dst_d, m_dst_d, w_dst_d;
   logic [1:0] e_tnew_d, m_tnew_d, w_tnew_d;
   logic [3:0] md_cnt_q, md_cnt_d;

   logic [2:0] rs_res, rt_res;
   logic       md_hazard;

   // Group 11 and the all-zero URA mark an empty slot that never matches.
   function automatic logic is_live(input logic [6:0] dst);
      return (dst != 7'd0) && (dst[6:5] != 2'b11);
   endfunction

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // Returns {hazard, fwd_sel} for one source, youngest stage wins.
   function automatic logic [2:0] resolve(
      input logic [6:0] src,
      input logic [1:0] tuse,
      input logic [6:0] e_dst, input logic [1:0] e_tnew,
      input logic [6:0] m_dst, input logic [1:0] m_tnew,
      input logic [6:0] w_dst, input logic [1:0] w_tnew
   );
      logic       hit;
      logic [1:0] code;
      logic [1:0] tnew;
      hit  = 1'b0;
      code = 2'b00;
      tnew = 2'd0;
      if (src != 7'd0) begin
         if (is_live(e_dst) && (e_dst == src)) begin
            hit = 1'b1; code = 2'b01; tnew = e_tnew;
         end else if (is_live(m_dst) && (m_dst == src)) begin
            hit = 1'b1; code = 2'b10; tnew = m_tnew;
         end else if (is_live(w_dst) && (w_dst == src)) begin
            hit = 1'b1; code = 2'b11; tnew = w_tnew;
         end
      end
      return {hit && (tnew > tuse), (hit && (tnew == 2'd0)) ? code : 2'b00};
   endfunction

   // Per-source hazard detection, mul/div hazard and the combined stall.
   always_comb begin
      rs_res = resolve(d_rs_ura, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
      rt_res = resolve(d_rt_ura, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
      md_busy    = (md_cnt_q != 4'd0);
      md_hazard  = md_busy && d_valid &&
                   (d_md_start || (d_rs_ura[6:5] == 2'b10) ||
                    (d_rt_ura[6:5] == 2'b10) || (d_dst_ura[6:5] == 2'b10));
      stall      = d_valid && (rs_res[2] || rt_res[2] || md_hazard);
      fwd_rs_sel = rs_res[1:0];
      fwd_rt_sel = rt_res[1:0];
   end

   // Next-state for the stage records and the mul/div counter.
   always_comb begin
      e_dst_d  = 7'd0;
      e_tnew_d = 2'd0;
      m_dst_d  = 7'd0;
      m_tnew_d = 2'd0;
      w_dst_d  = 7'd0;
      w_tnew_d = 2'd0;
      if (!flush) begin
         if (d_valid && !stall) begin
            e_dst_d  = d_dst_ura;
            e_tnew_d = d_tnew;
         end
         m_dst_d  = e_dst_q;
         m_tnew_d = tnew_dec(e_tnew_q);
         w_dst_d  = m_dst_q;
         w_tnew_d = tnew_dec(m_tnew_q);
      end
      if (d_md_start && d_valid && !stall)
         md_cnt_d = d_md_div ? DIV_CYCLES : MUL_CYCLES;
      else if (md_cnt_q != 4'd0)
         md_cnt_d = md_cnt_q - 4'd1;
      else
         md_cnt_d = 4'd0;
   end

   // Stage record registers, cleared to bubbles on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_dst_q  <= 7'd0;
         e_tnew_q <= 2'd0;
         m_dst_q  <= 7'd0;
         m_tnew_q <= 2'd0;
         w_dst_q  <= 7'd0;
         w_tnew_q <= 2'd0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         w_dst_q  <= w_dst_d;
         w_tnew_q <= w_tnew_d;
      end
   end

   // Mul/div occupancy counter; deliberately unaffected by flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) md_cnt_q <= 4'd0;
      else        md_cnt_q <= md_cnt_d;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic,
// checked against an in-flight producer list with absolute cycle stamps.
module tb_hazard_scoreboard;

   logic       clk;
   logic       reset;
   logic [6:0] d_rs_ura, d_rt_ura, d_dst_ura;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic       d_valid, d_md_start, d_md_div, flush;
   logic       stall, md_busy;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset),
      .d_rs_ura(d_rs_ura), .d_rt_ura(d_rt_ura),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_dst_ura(d_dst_ura), .d_tnew(d_tnew),
      .d_valid(d_valid), .d_md_start(d_md_start), .d_md_div(d_md_div),
      .flush(flush), .stall(stall),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] dst;
      int         enter;
      int         ready;
   } prod_t;

   typedef struct {
      logic       stall;
      logic [1:0] rs;
      logic [1:0] rt;
      logic       busy;
      string      tag;
   } exp_t;

   prod_t prods[$];
   exp_t  expq[$];
   int    cyc     = 0;
   int    md_done = 0;
   int    n_checks = 0;
   int    n_fail   = 0;

   task automatic chk(input string name, input string tag, input logic [3:0] act, input logic [3:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s/%s actual=%0h expected=%0h at cycle %0d", tag, name, act, expv, cyc);
      end
   endtask

   // Model: youngest in-flight producer of src; stage = cycles since E entry.
   function automatic void model_src(input logic [6:0] src, input logic [1:0] tuse,
                                     output logic hz, output logic [1:0] sel);
      int best;
      int rem;
      hz   = 1'b0;
      sel  = 2'b00;
      best = 99;
      rem  = 0;
      if (src == 7'd0) return;
      foreach (prods[i]) begin
         int st;
         st = cyc - prods[i].enter;
         if (st >= 0 && st <= 2 && prods[i].dst == src && st < best) begin
            best = st;
            rem  = prods[i].ready - cyc;
            if (rem < 0) rem = 0;
         end
      end
      if (best != 99) begin
         hz  = (rem > int'(tuse));
         sel = (rem == 0) ? 2'(best + 1) : 2'b00;
      end
   endfunction

   task automatic step(input string tag,
                       input logic [6:0] rs, input logic [6:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [6:0] dst, input logic [1:0] tn,
                       input logic v, input logic ms, input logic md,
                       input logic fl, input logic rb);
      exp_t       e;
      logic       hrs, hrt, hmd, busy;
      logic [1:0] srs, srt;
      @(negedge clk);
      d_rs_ura = rs;  d_rt_ura = rt;  d_tuse_rs = urs; d_tuse_rt = urt;
      d_dst_ura = dst; d_tnew = tn;   d_valid = v;     d_md_start = ms;
      d_md_div = md;  flush = fl;     reset = rb;
      e.tag = tag;
      if (!rb) begin
         prods.delete();
         md_done = 0;
         e.stall = 1'b0; e.rs = 2'b00; e.rt = 2'b00; e.busy = 1'b0;
      end else begin
         model_src(rs, urs, hrs, srs);
         model_src(rt, urt, hrt, srt);
         busy = (cyc < md_done);
         hmd  = busy && v && (ms || rs[6:5] == 2'b10 || rt[6:5] == 2'b10 || dst[6:5] == 2'b10);
         e.stall = v && (hrs || hrt || hmd);
         e.rs = srs; e.rt = srt; e.busy = busy;
      end
      expq.push_back(e);
      @(posedge clk);
      if (rb) begin
         if (fl) prods.delete();
         else if (v && !e.stall && dst != 7'd0 && dst[6:5] != 2'b11)
            prods.push_back('{dst: dst, enter: cyc + 1, ready: cyc + 1 + int'(tn)});
         if (ms && v && !e.stall) md_done = cyc + 1 + (md ? 10 : 5);
      end
      cyc++;
      while (prods.size() > 0 && cyc - prods[0].enter > 2) void'(prods.pop_front());
   endtask

   task automatic nop(input string tag);
      step(tag, 7'd0, 7'd0, 2'd0, 2'd0, 7'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   function automatic logic [6:0] pick_ura();
      logic [6:0] pool [8];
      pool[0] = 7'h00; pool[1] = 7'h05; pool[2] = 7'h08; pool[3] = 7'h2E;
      pool[4] = 7'h40; pool[5] = 7'h09; pool[6] = 7'h60; pool[7] = 7'(($urandom));
      return pool[$urandom_range(0, 7)];
   endfunction

   // Monitor: sample mid-low-phase, pop one expectation per presented cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall",      e.tag, {3'b0, stall},      {3'b0, e.stall});
            chk("fwd_rs_sel", e.tag, {2'b0, fwd_rs_sel}, {2'b0, e.rs});
            chk("fwd_rt_sel", e.tag, {2'b0, fwd_rt_sel}, {2'b0, e.rt});
            chk("md_busy",    e.tag, {3'b0, md_busy},    {3'b0, e.busy});
         end
      end
   end

   initial begin
      reset = 1'b0;
      d_rs_ura = '0; d_rt_ura = '0; d_tuse_rs = '0; d_tuse_rt = '0;
      d_dst_ura = '0; d_tnew = '0; d_valid = 1'b0; d_md_start = 1'b0;
      d_md_div = 1'b0; flush = 1'b0;

      step("reset", 7'h08, 7'h05, 2'd0, 2'd0, 7'h08, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step("reset", 7'h08, 7'h05, 2'd0, 2'd0, 7'h08, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nop("idle");

      // Load-use: two stall cycles, then forward from W.
      step("lw",       7'h00, 7'h00, 2'd0, 2'd0, 7'h08, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3)
         step("loaduse", 7'h08, 7'h00, 2'd0, 2'd0, 7'h09, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      nop("idle");

      // ALU forward: E wins over M.
      step("alu1",  7'h00, 7'h00, 2'd0, 2'd0, 7'h05, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("alu2",  7'h00, 7'h00, 2'd0, 2'd0, 7'h05, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("alufwd", 7'h00, 7'h05, 2'd0, 2'd1, 7'h0A, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      nop("idle");

      // $0 never hazards; eret-style URA 0x2E does.
      step("zero_w",  7'h00, 7'h00, 2'd0, 2'd0, 7'h00, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("zero_rd", 7'h00, 7'h00, 2'd0, 2'd0, 7'h0B, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("cp0_w",   7'h00, 7'h00, 2'd0, 2'd0, 7'h2E, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("cp0_rd",  7'h2E, 7'h00, 2'd0, 2'd0, 7'h0B, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) nop("idle");

      // Divide: busy for 10 cycles, HI/LO reader stalls throughout.
      step("div", 7'h01, 7'h02, 2'd0, 2'd0, 7'h00, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (12)
         step("hilo_rd", 7'h40, 7'h00, 2'd0, 2'd0, 7'h0C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Flush during a load-use stall; multiply keeps counting.
      step("mul",   7'h01, 7'h02, 2'd0, 2'd0, 7'h00, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step("lw",    7'h00, 7'h00, 2'd0, 2'd0, 7'h08, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step("flush", 7'h08, 7'h00, 2'd0, 2'd0, 7'h09, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step("postfl", 7'h08, 7'h00, 2'd0, 2'd0, 7'h09, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) nop("idle");

      // Async reset with the divide counter at 7.
      step("div", 7'h01, 7'h02, 2'd0, 2'd0, 7'h00, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (3) nop("divrun");
      step("areset", 7'h40, 7'h00, 2'd0, 2'd0, 7'h0C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("postrst", 7'h40, 7'h00, 2'd0, 2'd0, 7'h0C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      nop("idle");

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step("rand", pick_ura(), pick_ura(), 2'($urandom), 2'($urandom),
              pick_ura(), 2'($urandom), 1'($urandom_range(0, 9) != 0),
              1'($urandom_range(0, 11) == 0), 1'($urandom),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) != 0));
      end

      repeat (4) @(negedge clk);
      n_checks++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d pending expected=0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
